// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue
// Prefetch queue between the fetch stage and the decode stage. Holds up to
// DEPTH {pc, instruction} pairs, backpressures the PC when full, and drops
// everything buffered on a branch/jump redirect (flush_i).
// The head is presented combinationally from registered state, so an entry
// becomes visible to decode on the cycle after it is pushed (no fall-through).
module if_id_fetch_queue #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              fetch_valid_i,
    input  logic [N_BITS-1:0] fetch_pc_i,
    input  logic [N_BITS-1:0] fetch_instr_i,
    output logic              fetch_ready_o,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [N_BITS-1:0] dec_pc_o,
    output logic [N_BITS-1:0] dec_pc_plus4_o,
    output logic [N_BITS-1:0] dec_instr_o,
    output logic [PTR_W:0]    count_o
);

    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [N_BITS-1:0] PC_STEP    = N_BITS'(4);

    logic [N_BITS-1:0] mem_pc_reg    [DEPTH];
    logic [N_BITS-1:0] mem_instr_reg [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg,  count_next;

    logic push;
    logic pop;
    logic [N_BITS-1:0] head_pc;
    logic [N_BITS-1:0] head_instr;

    // Ready and valid come only from the registered count, so decode's ready
    // never reaches the fetch side combinationally.
    assign fetch_ready_o = (count_reg != FULL_COUNT);
    assign dec_valid_o   = (count_reg != '0);
    assign count_o       = count_reg;

    // A flush cancels whatever handshake happens in the same cycle.
    assign push = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop  = dec_valid_o   & dec_ready_i   & ~flush_i;

    assign head_pc    = mem_pc_reg[rd_ptr_reg];
    assign head_instr = mem_instr_reg[rd_ptr_reg];

    // Head outputs: show a NOP at pc 0 whenever nothing valid is buffered.
    always_comb begin
        dec_pc_o       = '0;
        dec_pc_plus4_o = PC_STEP;
        dec_instr_o    = '0;
        if (dec_valid_o) begin
            dec_pc_o       = head_pc;
            dec_pc_plus4_o = head_pc + PC_STEP;
            dec_instr_o    = head_instr;
        end
    end

    // Next-state for pointers and occupancy; DEPTH is a power of two so the
    // pointers wrap naturally at their width.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
                2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy registers; reset takes priority over flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage: cleared by reset, left untouched by flush (stale data is
    // hidden because the count drops to zero).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_reg[i]    <= '0;
                mem_instr_reg[i] <= '0;
            end
        end else if (push) begin
            mem_pc_reg[wr_ptr_reg]    <= fetch_pc_i;
            mem_instr_reg[wr_ptr_reg] <= fetch_instr_i;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed-vector bench for if_id_fetch_queue (N_BITS=32, DEPTH=4).
// Inputs change just after a falling edge; outputs are sampled on the next
// falling edge, i.e. half a cycle after the rising edge that updates state.
module tb_if_id_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_instr_i;
    logic        fetch_ready_o;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_pc_plus4_o;
    logic [31:0] dec_instr_o;
    logic [2:0]  count_o;

    int vectors;
    int miscompares;

    if_id_fetch_queue #(
        .N_BITS(32),
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_pc_plus4_o(dec_pc_plus4_o),
        .dec_instr_o   (dec_instr_o),
        .count_o       (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl);
        fetch_valid_i = v;
        fetch_pc_i    = pc;
        fetch_instr_i = instr;
        dec_ready_i   = rdy;
        flush_i       = fl;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset state
        tick();
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(dec_valid_o), 64'd0);
        check("rst_ready", 64'(fetch_ready_o), 64'd1);
        check("rst_pc", 64'(dec_pc_o), 64'h0);
        check("rst_pc4", 64'(dec_pc_plus4_o), 64'h4);
        check("rst_instr", 64'(dec_instr_o), 64'h0);
        reset = 1'b0;

        // First push into empty queue: visible one cycle later
        drive(1'b1, 32'h0040_0000, 32'h2008_0005, 1'b0, 1'b0);
        tick();
        check("lat_valid", 64'(dec_valid_o), 64'd1);
        check("lat_pc", 64'(dec_pc_o), 64'h0040_0000);
        check("lat_pc4", 64'(dec_pc_plus4_o), 64'h0040_0004);
        check("lat_instr", 64'(dec_instr_o), 64'h2008_0005);
        check("lat_count", 64'(count_o), 64'd1);

        // Fill to DEPTH
        drive(1'b1, 32'h0040_0004, 32'h2008_0006, 1'b0, 1'b0);
        tick();
        check("fill_count2", 64'(count_o), 64'd2);
        drive(1'b1, 32'h0040_0008, 32'h2008_0007, 1'b0, 1'b0);
        tick();
        check("fill_count3", 64'(count_o), 64'd3);
        drive(1'b1, 32'h0040_000C, 32'h2008_0008, 1'b0, 1'b0);
        tick();
        check("fill_count4", 64'(count_o), 64'd4);
        check("full_ready", 64'(fetch_ready_o), 64'd0);

        // Fifth push refused
        drive(1'b1, 32'h0040_0010, 32'h2008_0009, 1'b0, 1'b0);
        tick();
        check("refuse_count", 64'(count_o), 64'd4);
        check("refuse_head", 64'(dec_pc_o), 64'h0040_0000);

        // Pop while full with fetch_valid high: push still refused
        drive(1'b1, 32'h0040_0010, 32'h2008_0009, 1'b1, 1'b0);
        tick();
        check("fullpop_count", 64'(count_o), 64'd3);
        check("fullpop_ready", 64'(fetch_ready_o), 64'd1);
        check("drain_pc1", 64'(dec_pc_o), 64'h0040_0004);
        check("drain_in1", 64'(dec_instr_o), 64'h2008_0006);

        // Drain remaining entries in push order
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("drain_pc2", 64'(dec_pc_o), 64'h0040_0008);
        check("drain_in2", 64'(dec_instr_o), 64'h2008_0007);
        tick();
        check("drain_pc3", 64'(dec_pc_o), 64'h0040_000C);
        check("drain_in3", 64'(dec_instr_o), 64'h2008_0008);
        check("drain_count", 64'(count_o), 64'd1);
        tick();
        check("empty_count", 64'(count_o), 64'd0);
        check("empty_valid", 64'(dec_valid_o), 64'd0);
        check("empty_pc", 64'(dec_pc_o), 64'h0);
        check("empty_pc4", 64'(dec_pc_plus4_o), 64'h4);
        check("empty_instr", 64'(dec_instr_o), 64'h0);

        // Pop on empty is ignored
        tick();
        check("underflow_count", 64'(count_o), 64'd0);

        // Pointer wrap over 10 pushes with a concurrent pop each cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0040_1000 + 32'(4 * i), 32'h3000_0000 + 32'(i), 1'b1, 1'b0);
            tick();
            check($sformatf("wrap_count%0d", i), 64'(count_o), 64'd1);
            check($sformatf("wrap_pc%0d", i), 64'(dec_pc_o), 64'(32'h0040_1000 + 32'(4 * i)));
            check($sformatf("wrap_in%0d", i), 64'(dec_instr_o), 64'(32'h3000_0000 + 32'(i)));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("wrap_drain", 64'(count_o), 64'd0);

        // Simultaneous push and pop at count 2
        drive(1'b1, 32'h0040_0020, 32'h4000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0040_0024, 32'h4000_0002, 1'b0, 1'b0);
        tick();
        check("pp_pre", 64'(count_o), 64'd2);
        drive(1'b1, 32'h0040_0028, 32'h4000_0003, 1'b1, 1'b0);
        tick();
        check("pp_count", 64'(count_o), 64'd2);
        check("pp_head", 64'(dec_pc_o), 64'h0040_0024);

        // Flush at count 3 while pushing and popping
        drive(1'b1, 32'h0040_002C, 32'h4000_0004, 1'b0, 1'b0);
        tick();
        check("fl_pre", 64'(count_o), 64'd3);
        drive(1'b1, 32'h0040_0030, 32'h4000_0005, 1'b1, 1'b1);
        tick();
        check("fl_count", 64'(count_o), 64'd0);
        check("fl_valid", 64'(dec_valid_o), 64'd0);
        check("fl_ready", 64'(fetch_ready_o), 64'd1);
        drive(1'b1, 32'h0040_0040, 32'h1111_1111, 1'b0, 1'b0);
        tick();
        check("postfl_count", 64'(count_o), 64'd1);
        check("postfl_pc", 64'(dec_pc_o), 64'h0040_0040);
        check("postfl_instr", 64'(dec_instr_o), 64'h1111_1111);

        // PC + 4 wraps modulo 2^32
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hFFFF_FFFC, 32'h2222_2222, 1'b0, 1'b0);
        tick();
        check("pcwrap_pc", 64'(dec_pc_o), 64'hFFFF_FFFC);
        check("pcwrap_pc4", 64'(dec_pc_plus4_o), 64'h0);

        // Asynchronous reset mid-stream with 3 entries held
        drive(1'b1, 32'h0040_0050, 32'h5000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0040_0054, 32'h5000_0002, 1'b0, 1'b0);
        tick();
        check("arst_pre", 64'(count_o), 64'd3);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_valid", 64'(dec_valid_o), 64'd0);
        check("arst_instr", 64'(dec_instr_o), 64'h0);
        check("arst_ready", 64'(fetch_ready_o), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        check("arst_after", 64'(count_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
